pwm_deadtime_gen: RTL and testbench

PWM_DEADTIME_GEN -- requirements
Module: pwm_deadtime_gen

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_deadtime_channel.sv | 83 ++++++++
 rtl/pwm_deadtime_gen.sv | 73 +++++++
 tb/tb_pwm_deadtime_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM dead-time generator: channel state encoding,
// the default dead-time counter width and a level-to-side helper.
package pwm_pkg;

    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,
        CH_LOW  = 2'd1,
        CH_DEAD = 2'd2,
        CH_HIGH = 2'd3
    } ch_state_e;

    localparam int DEAD_WIDTH_DEFAULT = 8;

    function automatic ch_state_e side_of(input logic level);
        return level ? CH_HIGH : CH_LOW;
    endfunction

endpackage

// File: rtl/pwm_deadtime_channel.sv
// One half-bridge channel: OFF/LOW/DEAD/HIGH state machine with dead-time counter.
// Drives are decoded from the state register only, so high and low can never overlap.
module pwm_deadtime_channel
    import pwm_pkg::*;
#(
    parameter int DEAD_WIDTH = DEAD_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active_i,
    input  logic                  pwm_in_i,
    input  logic [DEAD_WIDTH-1:0] dead_time_i,
    output logic                  pwm_high_o,
    output logic                  pwm_low_o,
    output logic                  out_en_o
);

    localparam logic [DEAD_WIDTH-1:0] CNT_ZERO = DEAD_WIDTH'(0);
    localparam logic [DEAD_WIDTH-1:0] CNT_ONE  = DEAD_WIDTH'(1);

    ch_state_e             state_q, state_d;
    logic [DEAD_WIDTH-1:0] cnt_q, cnt_d;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CH_OFF;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; deadTime is only sampled when a gap is started
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!active_i) begin
            state_d = CH_OFF;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                CH_OFF: begin
                    if (dead_time_i == CNT_ZERO) begin
                        state_d = side_of(pwm_in_i);
                    end else begin
                        state_d = CH_DEAD;
                        cnt_d   = dead_time_i;
                    end
                end
                CH_LOW, CH_HIGH: begin
                    if (side_of(pwm_in_i) == state_q) begin
                        state_d = state_q;
                    end else if (dead_time_i == CNT_ZERO) begin
                        state_d = side_of(pwm_in_i);
                    end else begin
                        state_d = CH_DEAD;
                        cnt_d   = dead_time_i;
                    end
                end
                CH_DEAD: begin
                    // A zero count here is unreachable; treat it as expired rather than wrap
                    if (cnt_q <= CNT_ONE) begin
                        state_d = side_of(pwm_in_i);
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = CH_OFF;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    assign pwm_high_o = (state_q == CH_HIGH);
    assign pwm_low_o  = (state_q == CH_LOW);
    assign out_en_o   = (state_q != CH_OFF);

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Multi-channel PWM dead-time generator with optional fault latch.
// Define PWM_DEADTIME_FAULT_EN to add fault / faultClear / faultActive.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int OUTPUTS    = 4,
    parameter int DEAD_WIDTH = DEAD_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef PWM_DEADTIME_FAULT_EN
    input  logic                  fault,
    input  logic                  faultClear,
    output logic                  faultActive,
`endif
    input  logic                  enable,
    input  logic [DEAD_WIDTH-1:0] deadTime,
    input  logic [OUTPUTS-1:0]    pwm_en,
    input  logic [OUTPUTS-1:0]    pwm_in,
    output logic [OUTPUTS-1:0]    pwm_high,
    output logic [OUTPUTS-1:0]    pwm_low,
    output logic [OUTPUTS-1:0]    pwm_outEn
);

    logic force_off_s;

`ifdef PWM_DEADTIME_FAULT_EN
    logic fault_active_q, fault_active_d;

    // Fault latch register
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_active_q <= 1'b0;
        end else begin
            fault_active_q <= fault_active_d;
        end
    end

    // A live fault wins over a simultaneous clear
    always_comb begin
        fault_active_d = fault_active_q;
        if (fault) begin
            fault_active_d = 1'b1;
        end else if (faultClear) begin
            fault_active_d = 1'b0;
        end else begin
            fault_active_d = fault_active_q;
        end
    end

    // The raw fault is included so channels drop at the same edge the latch sets
    assign force_off_s = fault | fault_active_q;
    assign faultActive = fault_active_q;
`else
    assign force_off_s = 1'b0;
`endif

    for (genvar g = 0; g < OUTPUTS; g++) begin : g_ch
        pwm_deadtime_channel #(
            .DEAD_WIDTH (DEAD_WIDTH)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .active_i    (enable & pwm_en[g] & ~force_off_s),
            .pwm_in_i    (pwm_in[g]),
            .dead_time_i (deadTime),
            .pwm_high_o  (pwm_high[g]),
            .pwm_low_o   (pwm_low[g]),
            .out_en_o    (pwm_outEn[g])
        );
    end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Scoreboard bench for pwm_deadtime_gen: directed scenarios plus random stimulus
// against a behavioural channel model; fault scenarios run when PWM_DEADTIME_FAULT_EN is set.
module tb_pwm_deadtime_gen;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] deadTime = '0;
    logic [N-1:0]  pwm_en = '0;
    logic [N-1:0]  pwm_in = '0;
    logic [N-1:0]  pwm_high, pwm_low, pwm_outEn;
`ifdef PWM_DEADTIME_FAULT_EN
    logic fault = 1'b0, faultClear = 1'b0, faultActive;
`endif

    pwm_deadtime_gen #(.OUTPUTS(N), .DEAD_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef PWM_DEADTIME_FAULT_EN
        .fault      (fault),
        .faultClear (faultClear),
        .faultActive(faultActive),
`endif
        .enable     (enable),
        .deadTime   (deadTime),
        .pwm_en     (pwm_en),
        .pwm_in     (pwm_in),
        .pwm_high   (pwm_high),
        .pwm_low    (pwm_low),
        .pwm_outEn  (pwm_outEn)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] high;
        logic [N-1:0] low;
        logic [N-1:0] oe;
        logic         fa;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: what each channel is doing, and how many dead cycles remain
    localparam int M_OFF = 0, M_LOW = 1, M_DEAD = 2, M_HIGH = 3;
    int  mode_m [N];
    int  rem_m  [N];
    bit  fa_m;

    function automatic int want_side(input logic lvl);
        return lvl ? M_HIGH : M_LOW;
    endfunction

    task automatic model_edge(input bit r, input bit e, input logic [N-1:0] pe,
                              input logic [N-1:0] pin, input int dt, input bit f, input bit fc);
        bit forced;
        if (r) begin
            for (int i = 0; i < N; i++) begin mode_m[i] = M_OFF; rem_m[i] = 0; end
            fa_m = 1'b0;
            return;
        end
        forced = f | fa_m;
        if (f) fa_m = 1'b1;
        else if (fc) fa_m = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!(e && pe[i] && !forced)) begin
                mode_m[i] = M_OFF;
            end else if (mode_m[i] == M_DEAD) begin
                rem_m[i] = rem_m[i] - 1;
                if (rem_m[i] <= 0) mode_m[i] = want_side(pin[i]);
            end else if (mode_m[i] == M_OFF || mode_m[i] != want_side(pin[i])) begin
                if (dt == 0) mode_m[i] = want_side(pin[i]);
                else begin mode_m[i] = M_DEAD; rem_m[i] = dt; end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        for (int i = 0; i < N; i++) begin
            x.high[i] = (mode_m[i] == M_HIGH);
            x.low[i]  = (mode_m[i] == M_LOW);
            x.oe[i]   = (mode_m[i] != M_OFF);
        end
        x.fa = fa_m;
        return x;
    endfunction

    // Drive one cycle of inputs and queue the response expected after the next edge
    task automatic step(input bit r, input bit e, input logic [N-1:0] pe, input logic [N-1:0] pin,
                        input int dt, input bit f = 1'b0, input bit fc = 1'b0);
        @(negedge clk);
        rst = r; enable = e; pwm_en = pe; pwm_in = pin; deadTime = DW'(dt);
`ifdef PWM_DEADTIME_FAULT_EN
        fault = f; faultClear = fc;
`endif
        model_edge(r, e, pe, pin, dt, f, fc);
        exp_q.push_back(model_out());
    endtask

    task automatic run(input int cycles, input logic [N-1:0] pin, input int dt);
        for (int k = 0; k < cycles; k++) step(1'b0, 1'b1, '1, pin, dt);
    endtask

    // Monitor: every clock presents one output word, compared with the queue head
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (pwm_high !== x.high || pwm_low !== x.low || pwm_outEn !== x.oe) begin
                    errors++;
                    $display("FAIL outputs t=%0t: high=%b low=%b oe=%b, expected high=%b low=%b oe=%b",
                             $time, pwm_high, pwm_low, pwm_outEn, x.high, x.low, x.oe);
                end
                checks++;
                if ((pwm_high & pwm_low) !== '0) begin
                    errors++;
                    $display("FAIL overlap t=%0t: high&low=%b, expected 0", $time, pwm_high & pwm_low);
                end
`ifdef PWM_DEADTIME_FAULT_EN
                checks++;
                if (faultActive !== x.fa) begin
                    errors++;
                    $display("FAIL faultActive t=%0t: got %b, expected %b", $time, faultActive, x.fa);
                end
`endif
            end
        end
    end

    initial begin
        logic [N-1:0] pin, pe;
        int dt;
        bit e, r, f, fc;

        step(1'b1, 1'b0, '0, '0, 0);
        step(1'b1, 1'b0, '0, '0, 0);

        // dt=3: settle low, then rising edge -> 3 dead cycles before high
        run(6, '0, 3);
        run(8, '1, 3);

        // dt=0: square wave of period 8, direct complementary swaps
        for (int k = 0; k < 32; k++) run(1, ((k / 4) % 2 == 1) ? '1 : '0, 0);

        // dt=5: 2-cycle pulse from LOW is swallowed
        run(8, '0, 5);
        run(2, '1, 5);
        run(10, '0, 5);

        // dt 4 -> 10 mid-gap: current gap stays 4, next gap is 10
        run(6, '0, 4);
        run(2, '1, 4);
        run(6, '1, 10);
        run(14, '0, 10);

        // rst mid-DEAD, then re-enable
        run(6, '1, 3);
        run(1, '0, 3);
        step(1'b1, 1'b1, '1, '0, 3);
        run(8, '0, 3);

        // pwm_en dropped on channel 1 while HIGH, then restored
        run(6, '1, 2);
        step(1'b0, 1'b1, 4'b1101, '1, 2);
        step(1'b0, 1'b1, 4'b1101, '1, 2);
        run(6, '1, 2);

`ifdef PWM_DEADTIME_FAULT_EN
        // Fault during HIGH; clear ignored while fault held; clear restarts through DEAD
        run(6, '1, 3);
        step(1'b0, 1'b1, '1, '1, 3, 1'b1, 1'b0);
        step(1'b0, 1'b1, '1, '1, 3, 1'b0, 1'b0);
        step(1'b0, 1'b1, '1, '1, 3, 1'b1, 1'b1);
        step(1'b0, 1'b1, '1, '1, 3, 1'b0, 1'b0);
        step(1'b0, 1'b1, '1, '1, 3, 1'b0, 1'b1);
        run(8, '1, 3);
`endif

        // Random traffic
        pin = '0; pe = '1; dt = 2; e = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(5, 0) == 0) pin[i] = ~pin[i];
                if ($urandom_range(79, 0) == 0) pe[i] = ~pe[i];
            end
            if ($urandom_range(39, 0) == 0) dt = $urandom_range(6, 0);
            if ($urandom_range(99, 0) == 0) e = ~e;
            if ($urandom_range(20, 0) == 0) e = 1'b1;
            r  = ($urandom_range(299, 0) == 0);
            f  = ($urandom_range(149, 0) == 0);
            fc = ($urandom_range(9, 0) == 0);
`ifndef PWM_DEADTIME_FAULT_EN
            f = 1'b0; fc = 1'b0;
`endif
            step(r, e, pe, pin, dt, f, fc);
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
